// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_scheduler
// Description : Shares one uart_tx byte transmitter between NUM_REQ message
//               producers. Picks the next producer round-robin and streams
//               its message one byte at a time. uart_tx has no busy output,
//               so each byte is given a fixed BYTE_CYCLES time slot. After
//               every message the line stays idle for GAP_CYCLES cycles.
//
// Ports       : clk_50M    - system clock (single domain)
//               reset      - synchronous, active-high reset
//               req        - level request per requester
//               req_bytes  - current byte per requester, [8i+7:8i]
//               req_last   - presented byte is the last of the message
//               grant      - one-hot owner, from arbitration to end of message
//               byte_ack   - pulse: presented byte consumed, present the next
//               msg_done   - pulse: message completed or truncated
//               msg_trunc  - pulse with msg_done when MAX_BYTES cut it short
//               tx_data    - byte to uart_tx, held between data_send pulses
//               data_send  - one-cycle start strobe to uart_tx
//               busy       - scheduler is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int BYTE_CYCLES = 4340,
  parameter int GAP_CYCLES  = 434,
  parameter int MAX_BYTES   = 16
) (
  input  logic                   clk_50M,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_bytes,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     byte_ack,
  output logic [NUM_REQ-1:0]     msg_done,
  output logic                   msg_trunc,
  output logic [7:0]             tx_data,
  output logic                   data_send,
  output logic                   busy
);

  // --------------------------------------------------------------------------
  // Widths and constants
  // --------------------------------------------------------------------------
  localparam int c_ptr_w   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_cnt_w   = $clog2(MAX_BYTES + 1);
  localparam int c_tmr_max = (BYTE_CYCLES > GAP_CYCLES) ? BYTE_CYCLES : GAP_CYCLES;
  localparam int c_tmr_w   = (c_tmr_max > 1) ? $clog2(c_tmr_max) : 1;

  localparam logic [c_tmr_w-1:0] c_byte_last = c_tmr_w'(BYTE_CYCLES - 1);
  localparam logic [c_tmr_w-1:0] c_gap_last  = c_tmr_w'(GAP_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max   = c_cnt_w'(MAX_BYTES);
  localparam logic [c_ptr_w-1:0] c_ptr_top   = c_ptr_w'(NUM_REQ - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_send = 2'd1;
  localparam logic [1:0] c_st_wait = 2'd2;
  localparam logic [1:0] c_st_gap  = 2'd3;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]         r_state;
  logic [c_ptr_w-1:0] r_owner;     // index of the granted requester
  logic [c_ptr_w-1:0] r_rr;        // search start for the next arbitration
  logic [c_cnt_w-1:0] r_byte_cnt;  // bytes sent in the current message
  logic [c_tmr_w-1:0] r_timer;     // shared by the byte slot and the gap
  logic               r_last;      // byte in flight was flagged last

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic [1:0]         w_state_nxt;
  logic [c_ptr_w-1:0] w_win;
  logic [NUM_REQ-1:0] w_win_onehot;
  logic [7:0]         w_own_byte;
  logic               w_own_last;
  logic               w_own_req;
  logic               w_byte_end;
  logic               w_gap_end;
  logic               w_cnt_full;
  logic               w_msg_end;

  logic [NUM_REQ-1:0] w_grant_nxt;
  logic [NUM_REQ-1:0] w_ack_nxt;
  logic [NUM_REQ-1:0] w_done_nxt;
  logic               w_trunc_nxt;
  logic               w_send_nxt;
  logic [7:0]         w_tx_nxt;
  logic               w_last_nxt;
  logic [c_ptr_w-1:0] w_owner_nxt;
  logic [c_ptr_w-1:0] w_rr_nxt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic [c_tmr_w-1:0] w_timer_nxt;

  // --------------------------------------------------------------------------
  // Round-robin winner: first set req bit at or above r_rr, with wrap.
  // Offsets are scanned from farthest to nearest so the nearest one wins.
  // --------------------------------------------------------------------------
  always_comb begin
    w_win        = r_rr;
    w_win_onehot = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if ((i == ((int'(r_rr) + k) % NUM_REQ)) && req[i]) begin
          w_win = c_ptr_w'(i);
        end
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      w_win_onehot[i] = (w_win == c_ptr_w'(i));
    end
  end

  // Only the owner's inputs are looked at; other requesters may change
  // their byte and last lines freely.
  always_comb begin
    w_own_byte = '0;
    w_own_last = 1'b0;
    w_own_req  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner == c_ptr_w'(i)) begin
        w_own_byte = req_bytes[8*i +: 8];
        w_own_last = req_last[i];
        w_own_req  = req[i];
      end
    end
  end

  assign w_byte_end = (r_timer == c_byte_last);
  assign w_gap_end  = (r_timer == c_gap_last);
  assign w_cnt_full = (r_byte_cnt == c_cnt_max);
  // Message ends on last byte, byte limit, or owner abandoning its request.
  assign w_msg_end  = r_last | w_cnt_full | ~w_own_req;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (|req) begin
          w_state_nxt = c_st_send;
        end
      end
      c_st_send: begin
        w_state_nxt = c_st_wait;
      end
      c_st_wait: begin
        if (w_byte_end) begin
          w_state_nxt = w_msg_end ? c_st_gap : c_st_send;
        end
      end
      c_st_gap: begin
        if (w_gap_end) begin
          w_state_nxt = c_st_idle;
        end
      end
      default: begin
        w_state_nxt = c_st_idle;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic. Produces busy directly and the next values of all
  // registered outputs and datapath registers.
  // --------------------------------------------------------------------------
  always_comb begin
    busy        = (r_state != c_st_idle);
    w_grant_nxt = grant;
    w_ack_nxt   = '0;
    w_done_nxt  = '0;
    w_trunc_nxt = 1'b0;
    w_send_nxt  = 1'b0;
    w_tx_nxt    = tx_data;
    w_last_nxt  = r_last;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr;
    w_cnt_nxt   = r_byte_cnt;
    w_timer_nxt = r_timer;

    case (r_state)
      c_st_idle: begin
        w_timer_nxt = '0;
        w_cnt_nxt   = '0;
        if (|req) begin
          w_owner_nxt = w_win;
          w_grant_nxt = w_win_onehot;
        end
      end

      c_st_send: begin
        w_tx_nxt    = w_own_byte;
        w_last_nxt  = w_own_last;
        w_send_nxt  = 1'b1;
        w_ack_nxt   = grant;
        w_cnt_nxt   = r_byte_cnt + c_cnt_w'(1);
        w_timer_nxt = '0;
      end

      c_st_wait: begin
        if (w_byte_end) begin
          w_timer_nxt = '0;
          if (w_msg_end) begin
            w_grant_nxt = '0;
            w_cnt_nxt   = '0;
            // Explicit wrap so non-power-of-two NUM_REQ works.
            w_rr_nxt    = (r_owner == c_ptr_top) ? '0 : r_owner + c_ptr_w'(1);
            if (r_last) begin
              w_done_nxt = grant;
            end else if (w_cnt_full) begin
              w_done_nxt  = grant;
              w_trunc_nxt = 1'b1;
            end
            // An abandoned message ends silently: no msg_done.
          end
        end else begin
          w_timer_nxt = r_timer + c_tmr_w'(1);
        end
      end

      c_st_gap: begin
        w_timer_nxt = w_gap_end ? '0 : r_timer + c_tmr_w'(1);
      end

      default: begin
        w_grant_nxt = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      grant      <= '0;
      byte_ack   <= '0;
      msg_done   <= '0;
      msg_trunc  <= 1'b0;
      data_send  <= 1'b0;
      tx_data    <= 8'h00;
      r_last     <= 1'b0;
      r_owner    <= '0;
      r_rr       <= '0;
      r_byte_cnt <= '0;
      r_timer    <= '0;
    end else begin
      grant      <= w_grant_nxt;
      byte_ack   <= w_ack_nxt;
      msg_done   <= w_done_nxt;
      msg_trunc  <= w_trunc_nxt;
      data_send  <= w_send_nxt;
      tx_data    <= w_tx_nxt;
      r_last     <= w_last_nxt;
      r_owner    <= w_owner_nxt;
      r_rr       <= w_rr_nxt;
      r_byte_cnt <= w_cnt_nxt;
      r_timer    <= w_timer_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_scheduler
// Description : Self-checking bench for uart_tx_scheduler. A stimulus thread
//               drives the requesters and pushes predicted bytes and message
//               completions into queues. A monitor thread pops and compares
//               them whenever the DUT strobes data_send or msg_done. It also
//               checks byte spacing, done latency and gap length.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;

  localparam int NUM_REQ     = 4;
  localparam int BYTE_CYCLES = 8;
  localparam int GAP_CYCLES  = 2;
  localparam int MAX_BYTES   = 4;

  logic        clk_50M = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_bytes;
  logic [3:0]  req_last;
  logic [3:0]  grant;
  logic [3:0]  byte_ack;
  logic [3:0]  msg_done;
  logic        msg_trunc;
  logic [7:0]  tx_data;
  logic        data_send;
  logic        busy;

  uart_tx_scheduler #(
    .NUM_REQ    (NUM_REQ),
    .BYTE_CYCLES(BYTE_CYCLES),
    .GAP_CYCLES (GAP_CYCLES),
    .MAX_BYTES  (MAX_BYTES)
  ) dut (
    .clk_50M  (clk_50M),
    .reset    (reset),
    .req      (req),
    .req_bytes(req_bytes),
    .req_last (req_last),
    .grant    (grant),
    .byte_ack (byte_ack),
    .msg_done (msg_done),
    .msg_trunc(msg_trunc),
    .tx_data  (tx_data),
    .data_send(data_send),
    .busy     (busy)
  );

  always #5 clk_50M = ~clk_50M;

  typedef struct { logic [7:0] data; int owner; } exp_send_t;
  typedef struct { int owner; logic trunc; } exp_done_t;

  exp_send_t sq[$];
  exp_done_t dq[$];

  int n_total = 0;
  int n_bad   = 0;

  // Requester-side message storage
  logic [7:0] mem [NUM_REQ][16];
  int         msg_len  [NUM_REQ];
  bit         has_last [NUM_REQ];
  int         pos      [NUM_REQ];
  int         model_rr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] oh(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  task automatic present(input int i);
    req_bytes[8*i +: 8] = mem[i][pos[i]];
    req_last[i]         = has_last[i] && (pos[i] == msg_len[i] - 1);
  endtask

  task automatic load_msg(input int i, input int len, input bit hl, input bit rnd, input int base);
    for (int k = 0; k < 16; k++) begin
      mem[i][k] = rnd ? 8'($urandom) : 8'(base + k);
    end
    msg_len[i]  = len;
    has_last[i] = hl;
    pos[i]      = 0;
    present(i);
  endtask

  // One clock: step past the edge, then act as the requesters would.
  task automatic tick();
    @(posedge clk_50M);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (byte_ack[i] === 1'b1) begin
        if (pos[i] < 15) pos[i]++;
        present(i);
      end
      if (msg_done[i] === 1'b1) req[i] = 1'b0;
    end
  endtask

  // Reference model: a message yields min(len, MAX_BYTES) bytes when it
  // carries a last flag, else MAX_BYTES; it is truncated if the limit
  // arrives before the last flag.
  task automatic model_expect(input int i);
    int  n;
    logic tr;
    if (has_last[i]) begin
      n  = (msg_len[i] < MAX_BYTES) ? msg_len[i] : MAX_BYTES;
      tr = (msg_len[i] > MAX_BYTES);
    end else begin
      n  = MAX_BYTES;
      tr = 1'b1;
    end
    for (int k = 0; k < n; k++) sq.push_back(exp_send_t'{data: mem[i][k], owner: i});
    dq.push_back(exp_done_t'{owner: i, trunc: tr});
    model_rr = (i + 1) % NUM_REQ;
  endtask

  // All requesters in mask raise together from idle: they are served in
  // cyclic order starting at the round-robin position.
  task automatic batch(input logic [3:0] mask);
    int base;
    base = model_rr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (mask[(base + k) % NUM_REQ]) model_expect((base + k) % NUM_REQ);
    end
    req = mask;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n;
    n = 0;
    while ((busy !== 1'b0 || req != 4'b0) && n < max) begin
      tick();
      n++;
    end
    check(name, 32'((busy !== 1'b0) || (req != 4'b0)), 0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    req      = 4'b0;
    req_last = 4'b0;
    sq.delete();
    dq.delete();
    model_rr = 0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  initial begin : monitor
    int         mcyc;
    int         last_send;
    int         gfall;
    logic [3:0] pgrant;
    logic       pbusy;
    exp_send_t  es;
    exp_done_t  ed;
    mcyc = 0; last_send = -1; gfall = -1; pgrant = 4'b0; pbusy = 1'b0;
    forever begin
      @(negedge clk_50M);
      mcyc++;
      if (reset !== 1'b0) begin
        last_send = -1; gfall = -1; pgrant = 4'b0; pbusy = 1'b0;
      end else begin
        if (data_send === 1'b1) begin
          if (last_send >= 0) check("send_spacing", 32'(mcyc - last_send), BYTE_CYCLES + 1);
          last_send = mcyc;
          if (sq.size() == 0) begin
            check("send_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
          end else begin
            es = sq.pop_front();
            check("send_data", {24'h0, tx_data}, {24'h0, es.data});
            check("send_ack", {28'h0, byte_ack}, {28'h0, oh(es.owner)});
            check("send_grant", {28'h0, grant}, {28'h0, oh(es.owner)});
          end
        end
        if (msg_done != 4'b0) begin
          check("done_delay", 32'(mcyc - last_send), BYTE_CYCLES);
          check("done_grant_drop", {28'h0, grant}, 0);
          if (dq.size() == 0) begin
            check("done_unexpected", {28'h0, msg_done}, 0);
          end else begin
            ed = dq.pop_front();
            check("done_owner", {28'h0, msg_done}, {28'h0, oh(ed.owner)});
            check("done_trunc", {31'h0, msg_trunc}, {31'h0, ed.trunc});
          end
        end else if (msg_trunc !== 1'b0) begin
          check("stray_trunc", {31'h0, msg_trunc}, 0);
        end
        if (pgrant != 4'b0 && grant == 4'b0) begin
          gfall     = mcyc;
          last_send = -1;
        end
        if (pbusy && busy === 1'b0) check("gap_len", 32'(mcyc - gfall), GAP_CYCLES);
        pgrant = grant;
        pbusy  = busy;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: run exceeded time limit, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin : stimulus
    int         n;
    logic [3:0] mask;
    reset     = 1'b1;
    req       = 4'b0;
    req_bytes = 32'h0;
    req_last  = 4'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos[i] = 0; msg_len[i] = 1; has_last[i] = 1'b1;
      for (int k = 0; k < 16; k++) mem[i][k] = 8'h00;
    end
    repeat (3) tick();

    // Reset state
    check("rst_grant", {28'h0, grant}, 0);
    check("rst_byte_ack", {28'h0, byte_ack}, 0);
    check("rst_msg_done", {28'h0, msg_done}, 0);
    check("rst_msg_trunc", {31'h0, msg_trunc}, 0);
    check("rst_data_send", {31'h0, data_send}, 0);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_tx_data", {24'h0, tx_data}, 0);
    reset = 1'b0;

    // 1: three-byte message from requester 1
    load_msg(1, 3, 1'b1, 1'b0, 8'h41);
    model_expect(1);
    req = 4'b0010;
    tick();
    check("t1_grant_latency", {28'h0, grant}, 32'h2);
    check("t1_no_early_send", {31'h0, data_send}, 0);
    tick();
    check("t1_send_latency", {31'h0, data_send}, 1);
    check("t1_first_byte", {24'h0, tx_data}, 32'h41);
    wait_idle("t1_idle", 200);

    // 2: all four request together, two rounds, both starting at 0
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) load_msg(i, 1, 1'b1, 1'b1, 0);
    batch(4'b1111);
    tick();
    check("t2_first_grant", {28'h0, grant}, 32'h1);
    wait_idle("t2_idle_a", 300);
    for (int i = 0; i < NUM_REQ; i++) load_msg(i, 1, 1'b1, 1'b1, 0);
    batch(4'b1111);
    tick();
    check("t2_round2_grant", {28'h0, grant}, 32'h1);
    wait_idle("t2_idle_b", 300);

    // 3: no last flag -> truncated at MAX_BYTES
    load_msg(2, 8, 1'b0, 1'b1, 0);
    batch(4'b0100);
    wait_idle("t3_idle", 300);

    // 4: requester 3 abandons after its first byte
    load_msg(3, 3, 1'b1, 1'b1, 0);
    sq.push_back(exp_send_t'{data: mem[3][0], owner: 3});
    model_rr = 0;
    req = 4'b1000;
    n = 0;
    while (byte_ack[3] !== 1'b1 && n < 20) begin tick(); n++; end
    check("t4_ack_seen", {31'h0, byte_ack[3]}, 1);
    req[3] = 1'b0;
    wait_idle("t4_idle", 200);
    check("t4_single_send", 32'(sq.size()), 0);

    // 5: reset in the middle of a byte slot
    load_msg(0, 3, 1'b1, 1'b1, 0);
    model_expect(0);
    req = 4'b0001;
    n = 0;
    while (data_send !== 1'b1 && n < 20) begin tick(); n++; end
    check("t5_send_seen", {31'h0, data_send}, 1);
    repeat (3) tick();
    reset = 1'b1;
    req   = 4'b0;
    sq.delete();
    dq.delete();
    model_rr = 0;
    tick();
    check("t5_grant_cleared", {28'h0, grant}, 0);
    check("t5_busy_cleared", {31'h0, busy}, 0);
    check("t5_tx_cleared", {24'h0, tx_data}, 0);
    check("t5_send_cleared", {31'h0, data_send}, 0);
    reset = 1'b0;
    load_msg(0, 2, 1'b1, 1'b1, 0);
    model_expect(0);
    req = 4'b0001;
    tick();
    check("t5_fresh_grant", {28'h0, grant}, 32'h1);
    wait_idle("t5_idle", 200);

    // 6: requester 0 re-raises right after its msg_done while 1 waits
    do_reset();
    load_msg(0, 1, 1'b1, 1'b1, 0);
    model_expect(0);
    req = 4'b0001;
    tick();
    check("t6_grant0", {28'h0, grant}, 32'h1);
    load_msg(1, 2, 1'b1, 1'b1, 0);
    model_expect(1);
    req[1] = 1'b1;
    n = 0;
    while (msg_done[0] !== 1'b1 && n < 30) begin tick(); n++; end
    check("t6_done0_seen", {31'h0, msg_done[0]}, 1);
    tick();
    load_msg(0, 1, 1'b1, 1'b1, 0);
    model_expect(0);
    req[0] = 1'b1;
    n = 0;
    while (grant == 4'b0 && n < 10) begin tick(); n++; end
    check("t6_pending_first", {28'h0, grant}, 32'h2);
    wait_idle("t6_idle", 300);

    // Randomised batches
    repeat (12) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < NUM_REQ; i++) begin
        if (mask[i]) load_msg(i, $urandom_range(1, 6), ($urandom_range(0, 3) != 0), 1'b1, 0);
      end
      batch(mask);
      wait_idle("rand_idle", 800);
    end

    check("sb_send_drained", 32'(sq.size()), 0);
    check("sb_done_drained", 32'(dq.size()), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares the single uart_tx byte transmitter between several message producers: fault reporter, block-pick reporter, end-of-run reporter and debug.
- Arbitrates round-robin, streams one requester's message byte by byte, and paces bytes with a cycle timer, since uart_tx has no busy output.
- Sits in the clk_50M domain between the message producers and uart_tx (data, data_send).

Parameters:
- NUM_REQ, 4, number of requesters (index 0..NUM_REQ-1).
- BYTE_CYCLES, 4340, clk_50M cycles reserved per byte (10 bits x 434 at 115200 baud).
- GAP_CYCLES, 434, idle cycles inserted after each message before the next arbitration.
- MAX_BYTES, 16, maximum bytes per message; a message is force-terminated at this count.

Ports:
- clk_50M  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  level request per requester; held high until msg_done or abandoned.
- req_bytes  input  8*NUM_REQ  current byte of each requester; requester i occupies bits [8i+7:8i].
- req_last  input  NUM_REQ  the presented byte of requester i is the last byte of its message.
- grant  output  NUM_REQ  one-hot; high for the owner from arbitration until the end of its last byte.
- byte_ack  output  NUM_REQ  one-cycle pulse: the presented byte was consumed; the requester presents its next byte.
- msg_done  output  NUM_REQ  one-cycle pulse: the message completed normally or was truncated.
- msg_trunc  output  1  one-cycle pulse, coincident with msg_done, when MAX_BYTES was reached without req_last.
- tx_data  output  8  byte to uart_tx data; stable from its data_send pulse until the next one.
- data_send  output  1  one-cycle start strobe to uart_tx.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, SEND, WAIT, GAP.
- Reset, applied on any cycle including mid-message:
  - next state IDLE; rr pointer 0.
  - grant, byte_ack, msg_done, msg_trunc, data_send, busy all 0; tx_data 8'h00.
  - byte counter and timer cleared; no partial strobe survives.
- IDLE: if req is nonzero, the winner w is the first set bit searching upward from the rr pointer, with wrap. Register grant = onehot(w); go to SEND. If req is zero, stay.
- SEND (one cycle):
  - tx_data <= req_bytes[w]; last_r <= req_last[w].
  - Pulse data_send and byte_ack[w] in the next cycle.
  - byte_cnt <= byte_cnt+1; timer <= 0; go to WAIT.
- WAIT: timer increments each cycle. When timer == BYTE_CYCLES-1, exactly one of the following applies, in this priority:
  - last_r = 1: pulse msg_done[w]; go to GAP.
  - byte_cnt == MAX_BYTES: pulse msg_done[w] and msg_trunc; go to GAP.
  - req[w] = 0 (abandoned): no msg_done; go to GAP.
  - otherwise: go to SEND for the next byte.
- Leaving WAIT for GAP:
  - grant drops in the same cycle as the msg_done pulse.
  - rr pointer <= (w+1) mod NUM_REQ.
  - byte_cnt <= 0.
- GAP: count GAP_CYCLES cycles, then IDLE. No arbitration during GAP.
- Latency:
  - req rises while in IDLE at cycle t: grant at t+1; data_send, tx_data and byte_ack at t+2.
  - Consecutive data_send pulses are exactly BYTE_CYCLES+1 cycles apart.
- Requester contract: after byte_ack, the next byte must be valid within BYTE_CYCLES-1 cycles. Changes to a non-granted requester's req_bytes or req_last are ignored.
- Simultaneous requests: resolved by the rr pointer only. A requester that raises req during a message waits for the GAP to end.
- A requester raising req again in the cycle after its own msg_done is legal. It is granted next only if no other requester is pending.
- Widths:
  - byte_cnt holds 0..MAX_BYTES.
  - timer holds 0..max(BYTE_CYCLES, GAP_CYCLES)-1.
  - Pointer width is clog2(NUM_REQ), minimum 1.

Test Plan (BYTE_CYCLES=8, GAP_CYCLES=2, MAX_BYTES=4, NUM_REQ=4):
1. Reset, then req=4'b0010 with 3-byte message 8'h41,8'h42,8'h43 (last on 43) -> grant=0010 one cycle later; data_send pulses 9 cycles apart carrying 41,42,43; three byte_ack[1] pulses; msg_done[1] 8 cycles after the third data_send; busy low 2 cycles after that.
2. req=4'b1111 from IDLE, rr=0, each requester sends 1 byte -> grant order 0,1,2,3; next round starts at 0; each message yields exactly one data_send.
3. req[2] message with req_last never asserted -> exactly 4 data_send pulses; msg_done[2] and msg_trunc pulse together; grant drops.
4. req[3] deasserted after first byte_ack -> that byte completes; no second data_send; no msg_done; state passes through GAP to IDLE.
5. reset asserted in WAIT mid-message -> next cycle grant=0, busy=0, tx_data=00, data_send=0. Fresh req[0] then gets grant after one IDLE cycle.
6. req[0] re-raised the cycle after its msg_done while req[1] is pending -> requester 1 granted first, then 0.
